uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one UART transmitter among NREQ requesters; the transmitter has a go/txdata/txbusy interface.
- Latches the winning byte and drives go until txbusy is seen. Holds txdata stable for the whole frame, because the transmitter reads txdata bit-by-bit during the frame. Reports per-requester grant and done pulses.
- Sits between protocol engines (bridge, macro, self-test) and the single UART TX.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the requester index.
- TIMEOUT_CYCLES, 4096, watchdog limit in clk cycles. Used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req  in  NREQ  per-requester transmit request; level, held until grant.
- req_data  in  8*NREQ  byte for requester i at [8i+7:8i]; valid while req[i]=1.
- grant  out  NREQ  one-cycle pulse: byte accepted; requester may drop req/data next cycle.
- done  out  NREQ  one-cycle pulse: stop bit finished (txbusy fell) for that requester.
- uart_go  out  1  to UART go.
- uart_txdata  out  8  to UART txdata; registered and stable from launch until done.
- uart_txbusy  in  1  from UART txbusy.
- active  out  1  high in LAUNCH or WAIT_DONE.
- cur_id  out  IDW  index of the requester owning the UART; valid while active.
- err_timeout  out  1  sticky watchdog flag. Constant 0 without the macro.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: grant=0, done=0, uart_go=0, uart_txdata=8'h00, active=0, cur_id=0, err_timeout=0, state=IDLE, rr_ptr=0 (requester 0 has highest priority first).
- All outputs are registered.
- IDLE:
  - Grants only if |req and uart_txbusy==0. This guards against a UART frame still in flight after controller reset.
  - Winner: first i with req[i]=1, scanning from rr_ptr upward with modulo-NREQ wrap.
  - Next cycle: grant[winner]=1 (one cycle), uart_txdata<=req_data[winner], cur_id<=winner, uart_go<=1, state<=LAUNCH.
- LAUNCH:
  - Holds uart_go=1 until uart_txbusy==1 is sampled, then uart_go<=0 and state<=WAIT_DONE.
  - Expected dwell is 2 cycles, since the UART's txbusy lags go by 2 clocks.
- WAIT_DONE:
  - On uart_txbusy==0: done[cur_id]<=1 (one cycle), rr_ptr<=cur_id+1 (wrap to 0 past NREQ-1), state<=IDLE.
- Latency:
  - req rising in IDLE to grant: 1 cycle.
  - Back-to-back: at least one IDLE cycle between done and the next uart_go.
- Requests during LAUNCH/WAIT_DONE are ignored until IDLE (no queuing).
- req[i] dropped before grant: no grant, no done.
- req[cur_id] or req_data changing after grant: no effect on the frame in progress.
- Only one grant bit and one done bit are ever high in a cycle. grant and done never coincide.
- rst mid-frame:
  - Controller returns to IDLE and drops uart_go; the UART frame is not aborted.
  - No done is issued for the interrupted transfer.
  - The txbusy guard delays the next grant until the frame ends.
- Requester i that holds req permanently is served at most once per NREQ transfers while others request.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entering LAUNCH and runs in LAUNCH and WAIT_DONE.
  - When the counter reaches TIMEOUT_CYCLES: uart_go<=0, done[cur_id] pulses, err_timeout<=1 (sticky until rst), state<=IDLE.
  - Covers a UART held in reset or a stuck txbusy.
- Undefined: no counter; the controller waits indefinitely; err_timeout tied to 0.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE=2'b00, LAUNCH=2'b01, WAIT_DONE=2'b10}.
  - UART_BYTE_W=8.
  - Default TIMEOUT_CYCLES constant.
- Sub-module rr_pick:
  - Combinational masked priority encoder (req, rr_ptr -> winner, any).
  - Reused by later arbiters.

Test Plan:
- Single request: req=4'b0010, req_data[15:8]=8'hA5 -> grant=4'b0010 one cycle after req; uart_txdata=8'hA5 stable until done[1]; exactly one go assertion; done[1] one cycle after txbusy falls.
- Fairness: req=4'b1111 held, after reset -> grant order 0,1,2,3,0; each done precedes the next grant by at least 1 cycle.
- Wrap: rr_ptr=3 (last served 2), req=4'b1001 -> requester 3 granted, then requester 0.
- Busy guard: rst mid-frame with uart_txbusy=1 and req=4'b0001 -> no grant until txbusy=0; no done for the aborted transfer; then normal grant.
- Withdrawal: req[2] pulses for one cycle during WAIT_DONE -> no grant[2] ever.
- Timeout (macro on, TIMEOUT_CYCLES=16): uart_txbusy tied 0, req=4'b0100 -> go held 16 cycles, then done[2] and err_timeout=1 (sticky); controller returns to IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter family.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        LAUNCH    = 2'b01,
        WAIT_DONE = 2'b10
    } arb_state_e;

    localparam int UART_BYTE_W            = 8;
    localparam int TIMEOUT_CYCLES_DEFAULT = 4096;

    // Round-robin pointer successor: one past the last owner, wrapping at nreq.
    function automatic int rr_next(input int cur, input int nreq);
        return (cur >= nreq - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational masked priority encoder: first set request at or above ptr, with wrap.
module rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  winner,
    output logic            any
);

    // Scan NREQ slots starting at ptr; the first requesting slot is latched into winner.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int             sum;
            logic [IDW-1:0] idx;
            sum    = int'(ptr) + k;
            idx    = IDW'((sum >= NREQ) ? sum - NREQ : sum);
            winner = (!any && req[idx]) ? idx : winner;
            any    = any | req[idx];
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter (go/txdata/txbusy) among NREQ requesters.
// Optional watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int IDW            = $clog2(NREQ),
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req,
    input  logic [UART_BYTE_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]             grant,
    output logic [NREQ-1:0]             done,
    output logic                        uart_go,
    output logic [UART_BYTE_W-1:0]      uart_txdata,
    input  logic                        uart_txbusy,
    output logic                        active,
    output logic [IDW-1:0]              cur_id,
    output logic                        err_timeout
);

    arb_state_e             state_q, state_d;
    logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]         cur_id_q, cur_id_d;
    logic [NREQ-1:0]        grant_q, grant_d;
    logic [NREQ-1:0]        done_q, done_d;
    logic                   go_q, go_d;
    logic [UART_BYTE_W-1:0] txdata_q, txdata_d;
    logic                   active_q, active_d;
    logic [IDW-1:0]         winner_s;
    logic                   any_s;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_q, err_d;
`endif

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req    (req),
        .ptr    (rr_ptr_q),
        .winner (winner_s),
        .any    (any_s)
    );

    // Next-state and registered-output logic for the launch/wait sequencer.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cur_id_d = cur_id_q;
        grant_d  = '0;
        done_d   = '0;
        go_d     = go_q;
        txdata_d = txdata_q;
`ifdef UART_ARB_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                // txbusy guard: a frame left over from before a reset must finish first.
                if (any_s && !uart_txbusy) begin
                    grant_d[winner_s] = 1'b1;
                    txdata_d          = req_data[{winner_s, 3'b000} +: UART_BYTE_W];
                    cur_id_d          = winner_s;
                    go_d              = 1'b1;
                    state_d           = LAUNCH;
`ifdef UART_ARB_TIMEOUT_EN
                    tmo_cnt_d         = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            LAUNCH: begin
                if (uart_txbusy) begin
                    go_d    = 1'b0;
                    state_d = WAIT_DONE;
                end else begin
                    go_d = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!uart_txbusy) begin
                    done_d[cur_id_q] = 1'b1;
                    rr_ptr_d         = IDW'(rr_next(int'(cur_id_q), NREQ));
                    state_d          = IDLE;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            default: begin
                go_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
`ifdef UART_ARB_TIMEOUT_EN
        // Counter holds cycles spent in flight minus one, so go stays up TIMEOUT_CYCLES cycles.
        if (state_q == LAUNCH || state_q == WAIT_DONE) begin
            if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                go_d             = 1'b0;
                done_d           = '0;
                done_d[cur_id_q] = 1'b1;
                err_d            = 1'b1;
                rr_ptr_d         = IDW'(rr_next(int'(cur_id_q), NREQ));
                state_d          = IDLE;
            end else begin
                tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
            end
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end
`endif
        active_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            cur_id_q <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            go_q     <= 1'b0;
            txdata_q <= 8'h00;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cur_id_q <= cur_id_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            go_q     <= go_d;
            txdata_q <= txdata_d;
            active_q <= active_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign grant       = grant_q;
    assign done        = done_q;
    assign uart_go     = go_q;
    assign uart_txdata = txdata_q;
    assign active      = active_q;
    assign cur_id      = cur_id_q;

endmodule
